// File: rtl/mpu_hm_arbiter_pkg.sv
// Shared definitions for the host-memory arbiter: FSM state encoding and the
// default wait-timeout length.
package mpu_hm_arbiter_pkg;

    localparam int DEF_TIMEOUT = 1024;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        WAIT  = ST_WAIT,
        RESP  = ST_RESP
    } state_t;

endpackage

// File: rtl/mpu_hm_arbiter_if.sv
// Host-memory read port between the arbiter and the host-memory bridge.
//   hm_addr  : read address (arbiter -> bridge)
//   hm_start : 1-cycle read strobe (arbiter -> bridge)
//   hm_data  : read data, valid with hm_ack (bridge -> arbiter)
//   hm_ack   : 1-cycle read completion (bridge -> arbiter)
interface mpu_hm_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] hm_addr;
    logic              hm_start;
    logic [DATA_W-1:0] hm_data;
    logic              hm_ack;

    // arbiter side
    modport master (output hm_addr, output hm_start, input hm_data, input hm_ack);
    // bridge side
    modport slave  (input hm_addr, input hm_start, output hm_data, output hm_ack);
endinterface

// File: rtl/mpu_hm_arbiter_rr.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : highest-priority index for this decision
//   grant : first requesting index at or after ptr, wrapping
//   any   : at least one request present
module mpu_hm_arbiter_rr #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant,
    output logic             any
);
    logic [IDX_W-1:0] cand;

    // Scan from the furthest candidate back toward ptr so that the closest
    // requester (in wrapped order) is the last writer and wins.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = N_REQ-1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr) + k) % N_REQ);
            if (req[cand]) begin
                grant = cand;
                any   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mpu_hm_arbiter.sv
// Shares one host-memory read port between N_REQ MPU cores with round-robin
// grants. A requesting core is frozen (req_en low) until its data returns.
//   sys_clk, sys_rst : clock, asynchronous active-low reset
//   en               : global enable; 0 blocks new grants and holds cores
//   req_start        : per-core read request (level)
//   req_addr         : per-core read address, core i in element i
//   req_en           : per-core enable back to the cores
//   req_data         : returned data, shared by all cores
//   req_done         : one-hot single-cycle completion pulse
//   grant_idx        : current/last granted core
//   timeout_err      : sticky, set when a read is force-completed
//   hm               : host-memory bridge port
module mpu_hm_arbiter
    import mpu_hm_arbiter_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int ADDR_W  = 64,
    parameter  int DATA_W  = 64,
    parameter  int TIMEOUT = DEF_TIMEOUT,
    localparam int IDX_W   = $clog2(N_REQ),
    localparam int CNT_W   = $clog2(TIMEOUT)
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          en,
    input  logic [N_REQ-1:0]              req_start,
    input  logic [N_REQ-1:0][ADDR_W-1:0]  req_addr,
    output logic [N_REQ-1:0]              req_en,
    output logic [DATA_W-1:0]             req_data,
    output logic [N_REQ-1:0]              req_done,
    output logic [IDX_W-1:0]              grant_idx,
    output logic                          timeout_err,
    mpu_hm_arbiter_if.master              hm
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT-1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ-1);

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  rr_grant;
    logic              rr_any;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [N_REQ-1:0]  eligible;
    logic              grant_take;
    logic              timed_out;

    // A core whose done pulses this cycle is no longer waiting on us.
    assign eligible = req_start & ~req_done;
    assign req_en   = {N_REQ{en}} & (~req_start | req_done);

    mpu_hm_arbiter_rr #(.N_REQ(N_REQ)) u_rr (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (rr_grant),
        .any   (rr_any)
    );

    assign hm.hm_addr  = addr_q;
    assign hm.hm_start = (state == ISSUE);

    // Ack takes priority over the timeout when both land on the last cycle.
    assign timed_out = (state == WAIT) && !hm.hm_ack && (cnt == CNT_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        grant_take = 1'b0;
        req_done   = '0;
        case (state)
            IDLE: begin
                if (en && rr_any) begin
                    grant_take = 1'b1;
                    state_nxt  = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (hm.hm_ack || timed_out) state_nxt = RESP;
            end
            RESP: begin
                req_done[grant_idx] = 1'b1;
                state_nxt           = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            rr_ptr      <= '0;
            grant_idx   <= '0;
            addr_q      <= '0;
            req_data    <= '0;
            timeout_err <= 1'b0;
            cnt         <= '0;
        end else begin
            // Address is captured once at grant; later req_addr changes are ignored.
            if (grant_take) begin
                grant_idx <= rr_grant;
                addr_q    <= req_addr[rr_grant];
                rr_ptr    <= (rr_grant == IDX_LAST) ? '0 : rr_grant + 1'b1;
            end
            if (state == ISSUE)
                cnt <= '0;
            else if (state == WAIT && !hm.hm_ack)
                cnt <= cnt + 1'b1;
            if (state == WAIT && hm.hm_ack)
                req_data <= hm.hm_data;
            else if (timed_out) begin
                req_data    <= '0;
                timeout_err <= 1'b1;
            end
        end
    end
endmodule
